ps2_scancode_rx: RTL and testbench

Parametrised PS/2 device-to-host receiver with glitch filtering, full frame checking and make/break/extended prefix decoding. It emits one decoded key event per key action through a valid/ready FIFO interface. It replaces single-byte, no-handshake scancode capture in keyboard labs, and feeds ASCII mappers, game logic and LED counters.

---
 rtl/ps2_scancode_rx_if.sv | 25 ++
 rtl/ps2_scancode_rx.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_rx_if.sv
// Decoded key-event stream: show-ahead valid/ready handshake out of the PS/2 receiver.
// The master drives events; the slave consumes them.
interface ps2_scancode_rx_if;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_scancode;
   logic       out_released;
   logic       out_extended;

   modport master (
      output out_valid,
      output out_scancode,
      output out_released,
      output out_extended,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_scancode,
      input  out_released,
      input  out_extended,
      output out_ready
   );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronise, glitch-filter, frame-check and decode E0/F0 prefixes.
// Each decoded key action is queued as one event in a small show-ahead FIFO.
module ps2_scancode_rx #(
   parameter int unsigned SAMPLE_DIV    = 250,
   parameter int unsigned FILTER_LEN    = 4,
   parameter int unsigned TIMEOUT_TICKS = 4000,
   parameter int unsigned FIFO_DEPTH    = 8,
   localparam int unsigned CntW         = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ps2_clk_i,
   input  logic                ps2_data_i,
   ps2_scancode_rx_if.master   out_if,
   output logic                err_parity_o,
   output logic                err_frame_o,
   output logic                overflow_o,
   output logic [CntW-1:0]     fifo_count_o
);

   localparam int unsigned DivW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int unsigned ToW   = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);

   localparam logic [DivW-1:0]  DivLast  = DivW'(SAMPLE_DIV - 1);
   localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);
   localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT_TICKS - 1);
   localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

   // ---------------- synchronisers, sample divider, clock filter ----------------
   logic clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
      end else begin
         clk_meta_q  <= ps2_clk_i;
         clk_sync_q  <= clk_meta_q;
         data_meta_q <= ps2_data_i;
         data_sync_q <= data_meta_q;
      end
   end

   logic [DivW-1:0]  div_q, div_d;
   logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
   logic             clk_filt_q, clk_filt_d;
   logic             tick, fall;

   assign tick  = (div_q == DivLast);
   assign div_d = tick ? '0 : div_q + DivW'(1);

   // The filtered clock flips only after FILTER_LEN consecutive ticks disagreeing with it.
   always_comb begin
      filt_cnt_d = filt_cnt_q;
      clk_filt_d = clk_filt_q;
      fall       = 1'b0;
      if (tick) begin
         if (clk_sync_q != clk_filt_q) begin
            if (filt_cnt_q == FiltLast) begin
               clk_filt_d = clk_sync_q;
               filt_cnt_d = '0;
               fall       = clk_filt_q;
            end else begin
               filt_cnt_d = filt_cnt_q + FiltW'(1);
            end
         end else begin
            filt_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q      <= '0;
         filt_cnt_q <= '0;
         clk_filt_q <= 1'b1;
      end else begin
         div_q      <= div_d;
         filt_cnt_q <= filt_cnt_d;
         clk_filt_q <= clk_filt_d;
      end
   end

   // ---------------- frame FSM ----------------
   state_e           state_q, state_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [10:0]      frame_q, frame_d;
   logic [ToW-1:0]   to_cnt_q, to_cnt_d;
   logic             byte_ok_q, byte_ok_d;
   logic [7:0]       byte_q, byte_d;
   logic             err_par_q, err_par_d;
   logic             err_frm_q, err_frm_d;

   // Bits shift in from the top so that after 11 captures frame_q[0] is the start bit.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      frame_d   = frame_q;
      to_cnt_d  = to_cnt_q;
      byte_ok_d = 1'b0;
      byte_d    = byte_q;
      err_par_d = 1'b0;
      err_frm_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (fall) begin
               frame_d   = {data_sync_q, frame_q[10:1]};
               bit_cnt_d = 4'd1;
               to_cnt_d  = '0;
               state_d   = StRecv;
            end
         end
         StRecv: begin
            if (fall) begin
               frame_d  = {data_sync_q, frame_q[10:1]};
               to_cnt_d = '0;
               if (bit_cnt_q == 4'd10) begin
                  bit_cnt_d = '0;
                  state_d   = StCheck;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else if (tick) begin
               if (to_cnt_q == ToLast) begin
                  err_frm_d = 1'b1;
                  bit_cnt_d = '0;
                  to_cnt_d  = '0;
                  state_d   = StIdle;
               end else begin
                  to_cnt_d = to_cnt_q + ToW'(1);
               end
            end
         end
         StCheck: begin
            state_d = StIdle;
            if (frame_q[0] || !frame_q[10]) begin
               err_frm_d = 1'b1;
            end else if (!(^frame_q[9:1])) begin
               err_par_d = 1'b1;
            end else begin
               byte_ok_d = 1'b1;
               byte_d    = frame_q[8:1];
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         frame_q   <= '0;
         to_cnt_q  <= '0;
         byte_ok_q <= 1'b0;
         byte_q    <= '0;
         err_par_q <= 1'b0;
         err_frm_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         frame_q   <= frame_d;
         to_cnt_q  <= to_cnt_d;
         byte_ok_q <= byte_ok_d;
         byte_q    <= byte_d;
         err_par_q <= err_par_d;
         err_frm_q <= err_frm_d;
      end
   end

   // ---------------- prefix decoder ----------------
   logic       ext_q, ext_d, rel_q, rel_d, push;
   logic [9:0] push_data;

   always_comb begin
      ext_d = ext_q;
      rel_d = rel_q;
      push  = 1'b0;
      if (err_par_q || err_frm_q) begin
         ext_d = 1'b0;
         rel_d = 1'b0;
      end else if (byte_ok_q) begin
         if (byte_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (byte_q == 8'hF0) begin
            rel_d = 1'b1;
         end else begin
            push  = 1'b1;
            ext_d = 1'b0;
            rel_d = 1'b0;
         end
      end
   end

   assign push_data = {byte_q, rel_q, ext_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext_q <= 1'b0;
         rel_q <= 1'b0;
      end else begin
         ext_q <= ext_d;
         rel_q <= rel_d;
      end
   end

   // ---------------- event FIFO ----------------
   logic [9:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            pop, full, wr_en;

   assign pop   = (count_q != '0) && out_if.out_ready;
   assign full  = (count_q == CntFull);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign wr_en = push && (!full || pop);
   assign ovf_d = push && full && !pop;

   always_comb begin
      count_d = count_q;
      if (wr_en && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (!wr_en && pop) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_if.out_valid = (count_q != '0);
   assign {out_if.out_scancode, out_if.out_released, out_if.out_extended} = mem_q[rd_ptr_q];

   assign err_parity_o = err_par_q;
   assign err_frame_o  = err_frm_q;
   assign overflow_o   = ovf_q;
   assign fifo_count_o = count_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: drives PS/2 frames and compares decoded events
// against a byte-level model of the make/break/extended prefix rules and FIFO capacity.
module tb_ps2_scancode_rx;
   localparam int unsigned SD = 4, FL = 2, TO = 40, DEPTH = 4, HALF = 24;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic          clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic          err_parity, err_frame, overflow;
   logic [CW-1:0] fifo_count;

   ps2_scancode_rx_if out_if();

   ps2_scancode_rx #(
      .SAMPLE_DIV(SD), .FILTER_LEN(FL), .TIMEOUT_TICKS(TO), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data), .out_if(out_if),
      .err_parity_o(err_parity), .err_frame_o(err_frame), .overflow_o(overflow),
      .fifo_count_o(fifo_count)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int n_par = 0, n_frm = 0, n_ovf = 0;
   logic [9:0] obs_q[$], exp_q[$];
   bit m_ext = 0, m_rel = 0, model_ready = 1;
   int exp_ovf = 0;

   // Event/pulse log, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_if.out_valid && out_if.out_ready)
            obs_q.push_back({out_if.out_scancode, out_if.out_released, out_if.out_extended});
         if (err_parity) n_par++;
         if (err_frame)  n_frm++;
         if (overflow)   n_ovf++;
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Reference model: one call per received byte.
   function automatic void model_byte(input logic [7:0] b, input bit good);
      if (!good) begin
         m_ext = 0; m_rel = 0;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_rel = 1;
      end else begin
         if (!model_ready && exp_q.size() >= int'(DEPTH)) exp_ovf++;
         else exp_q.push_back({b, m_rel, m_ext});
         m_ext = 0; m_rel = 0;
      end
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic set_ready(input bit v);
      @(posedge clk);
      #1;
      out_if.out_ready = v;
      model_ready = v;
   endtask

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         wait_cyc(HALF);
         ps2_clk = 1'b0;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
      wait_cyc(HALF);
      ps2_data = 1'b1;
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit flip, input bit stop);
      logic par;
      par = (~^b) ^ flip;
      return {stop, par, b, 1'b0};
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit flip, input bit stop);
      send_bits(mk_frame(b, flip, stop), 11);
      model_byte(b, !flip && stop);
      wait_cyc(8);
   endtask

   task automatic clear_logs();
      obs_q.delete();
      exp_q.delete();
      exp_ovf = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_cyc(5);
      total++;
      if ({out_if.out_valid, out_if.out_scancode, out_if.out_released, out_if.out_extended,
           err_parity, err_frame, overflow, fifo_count} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got valid=%b sc=%h cnt=%0d want all zero",
                  out_if.out_valid, out_if.out_scancode, fifo_count);
      end
      rst = 1'b0;
      wait_cyc(5);
   endtask

   task automatic test_basic();
      int p0 = n_par, f0 = n_frm;
      clear_logs();
      send_byte(8'h1C, 0, 1);
      total++;
      if (obs_q.size() !== 1) begin
         bad++; $display("FAIL basic_count got=%0d want=1", obs_q.size());
      end else begin
         total++;
         if (obs_q[0] !== {8'h1C, 1'b0, 1'b0}) begin
            bad++; $display("FAIL basic_event got=%h want=%h", obs_q[0], {8'h1C, 2'b00});
         end
      end
      total++;
      if (n_par != p0 || n_frm != f0) begin
         bad++; $display("FAIL basic_errors got par=%0d frm=%0d want 0", n_par - p0, n_frm - f0);
      end
   endtask

   task automatic test_prefix();
      clear_logs();
      send_byte(8'hE0, 0, 1);
      send_byte(8'hF0, 0, 1);
      send_byte(8'h75, 0, 1);
      send_byte(8'h72, 0, 1);
      total++;
      if (obs_q.size() !== exp_q.size()) begin
         bad++; $display("FAIL prefix_count got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++; $display("FAIL prefix_event%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
         end
      end
      total++;
      if (obs_q.size() > 0 && obs_q[0] !== {8'h75, 1'b1, 1'b1}) begin
         bad++; $display("FAIL prefix_e0f075 got=%h want=%h", obs_q[0], {8'h75, 2'b11});
      end
   endtask

   task automatic test_parity();
      int p0 = n_par;
      clear_logs();
      send_byte(8'hF0, 0, 1);
      send_byte(8'h15, 1, 1);
      send_byte(8'h1C, 0, 1);
      total++;
      if (n_par - p0 != 1) begin
         bad++; $display("FAIL parity_pulse got=%0d want=1", n_par - p0);
      end
      total++;
      if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
         bad++; $display("FAIL parity_event got n=%0d ev=%h want n=1 ev=%h",
                         obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 10'h0, exp_q[0]);
      end
   endtask

   task automatic test_framing();
      int f0 = n_frm;
      clear_logs();
      send_bits(mk_frame(8'h29, 0, 1), 5);
      model_byte(8'h00, 0);
      wait_cyc((TO + 10) * SD);
      total++;
      if (n_frm - f0 != 1 || obs_q.size() != 0) begin
         bad++; $display("FAIL timeout got frm=%0d ev=%0d want frm=1 ev=0",
                         n_frm - f0, obs_q.size());
      end
      send_byte(8'h29, 0, 1);
      total++;
      if (obs_q.size() !== 1 || obs_q[0] !== {8'h29, 2'b00}) begin
         bad++; $display("FAIL after_timeout got n=%0d want event 29", obs_q.size());
      end
      f0 = n_frm;
      send_byte(8'h29, 0, 0);
      total++;
      if (n_frm - f0 != 1 || obs_q.size() !== exp_q.size()) begin
         bad++; $display("FAIL stop_bit got frm=%0d ev=%0d want frm=1 ev=%0d",
                         n_frm - f0, obs_q.size(), exp_q.size());
      end
   endtask

   task automatic test_overflow();
      int o0 = n_ovf;
      logic [7:0] keys [5];
      keys[0] = 8'h16; keys[1] = 8'h1E; keys[2] = 8'h26; keys[3] = 8'h25; keys[4] = 8'h2E;
      clear_logs();
      set_ready(0);
      for (int i = 0; i < 5; i++) send_byte(keys[i], 0, 1);
      total++;
      if (int'(fifo_count) != exp_q.size()) begin
         bad++; $display("FAIL ovf_count got=%0d want=%0d", fifo_count, exp_q.size());
      end
      total++;
      if (n_ovf - o0 != exp_ovf) begin
         bad++; $display("FAIL ovf_pulse got=%0d want=%0d", n_ovf - o0, exp_ovf);
      end
      total++;
      if (out_if.out_valid !== 1'b1 || out_if.out_scancode !== 8'h16) begin
         bad++; $display("FAIL ovf_head got v=%b sc=%h want v=1 sc=16",
                         out_if.out_valid, out_if.out_scancode);
      end
      set_ready(1);
      wait_cyc(10);
      total++;
      if (obs_q.size() !== exp_q.size()) begin
         bad++; $display("FAIL ovf_drain got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++; $display("FAIL ovf_order%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
         end
      end
      total++;
      if (out_if.out_valid !== 1'b0) begin
         bad++; $display("FAIL ovf_empty got valid=%b want 0", out_if.out_valid);
      end
   endtask

   task automatic test_glitch_and_reset();
      int f0 = n_frm, p0 = n_par;
      clear_logs();
      @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (3) @(posedge clk);
      #1 ps2_clk = 1'b1;
      wait_cyc((TO + 10) * SD);
      send_byte(8'h5A, 0, 1);
      total++;
      if (n_frm != f0 || n_par != p0 || obs_q.size() !== 1 || obs_q[0] !== {8'h5A, 2'b00}) begin
         bad++; $display("FAIL glitch got frm=%0d par=%0d ev=%0d want 0 0 1",
                         n_frm - f0, n_par - p0, obs_q.size());
      end
      set_ready(0);
      send_byte(8'h2E, 0, 1);
      send_byte(8'hF0, 0, 1);
      send_bits(mk_frame(8'h33, 0, 1), 7);
      rst = 1'b1;
      #1;
      total++;
      if ({out_if.out_valid, out_if.out_scancode, out_if.out_released, out_if.out_extended,
           fifo_count, err_parity, err_frame, overflow} !== '0) begin
         bad++; $display("FAIL midreset got valid=%b sc=%h cnt=%0d want all zero",
                         out_if.out_valid, out_if.out_scancode, fifo_count);
      end
      clear_logs();
      m_ext = 0; m_rel = 0;
      wait_cyc(10);
      rst = 1'b0;
      set_ready(1);
      wait_cyc(5);
      send_byte(8'h1D, 0, 1);
      total++;
      if (obs_q.size() !== 1 || obs_q[0] !== {8'h1D, 2'b00}) begin
         bad++; $display("FAIL after_reset got n=%0d ev=%h want n=1 ev=%h", obs_q.size(),
                         (obs_q.size() > 0) ? obs_q[0] : 10'h0, {8'h1D, 2'b00});
      end
   endtask

   task automatic test_random();
      int p0 = n_par, exp_par = 0;
      logic [7:0] code;
      clear_logs();
      for (int k = 0; k < 14; k++) begin
         if ($urandom_range(0, 1) == 1) send_byte(8'hE0, 0, 1);
         if ($urandom_range(0, 1) == 1) send_byte(8'hF0, 0, 1);
         if ($urandom_range(0, 5) == 0) begin
            send_byte(8'($urandom_range(0, 255)), 1, 1);
            exp_par++;
         end
         code = 8'($urandom_range(0, 255));
         for (int t = 0; t < 8 && (code == 8'hE0 || code == 8'hF0); t++)
            code = 8'($urandom_range(1, 127));
         send_byte(code, 0, 1);
      end
      total++;
      if (obs_q.size() !== exp_q.size()) begin
         bad++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i]) begin
            bad++; $display("FAIL rand_event%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
         end
      end
      total++;
      if (n_par - p0 != exp_par) begin
         bad++; $display("FAIL rand_parity got=%0d want=%0d", n_par - p0, exp_par);
      end
   endtask

   initial begin
      out_if.out_ready = 1'b1;
      model_ready = 1;
      test_reset();
      test_basic();
      test_prefix();
      test_parity();
      test_framing();
      test_overflow();
      test_glitch_and_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
